timer_share_arb: RTL and testbench

- Arbiter and sequencer that shares one terminal-count interval counter among NREQ requesters.
- Each requester asks for an interval of len+1 clock cycles. The block grants round-robin, runs the shared counter from 0 up to len, then pulses done to the winner.
- Sits between the control agents and the counter datapath and provides the only sequencing of that counter.

---
 rtl/timer_share_arb_if.sv | 24 ++
 rtl/timer_share_arb.sv | 136 +++++++++++++
 tb/tb_timer_share_arb.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_share_arb_if.sv
// Handshake bundle between the requesting agents and timer_share_arb.
// The agents use the master modport; the arbiter uses the slave modport.
interface timer_share_arb_if #(
    parameter int NREQ = 4,
    parameter int CW   = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] len;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               busy;
    logic [CW-1:0]      cnt;
    logic               last;

    modport master (
        output req, len,
        input  gnt, done, busy, cnt, last
    );

    modport slave (
        input  req, len,
        output gnt, done, busy, cnt, last
    );
endinterface

// File: rtl/timer_share_arb.sv
// Round-robin arbiter/sequencer sharing one terminal-count interval counter among NREQ agents.
// Define TIMER_SHARE_ARB_B2B_EN to re-arbitrate straight out of DONE without an IDLE bubble.
module timer_share_arb #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic              clk,
    input  logic              rstn,
    timer_share_arb_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   term_q, term_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   win_q, win_d;

    logic [NREQ-1:0] arb_req;
    logic            arb_vld;
    logic [IW-1:0]   arb_idx;
    logic            win_req;
    logic            at_term;
    logic            grant_now;

    // First set bit at or above p, wrapping; the MSB of the result flags "found".
    function automatic logic [IW:0] rr_first(input logic [NREQ-1:0] r,
                                             input logic [IW-1:0]   p);
        logic [IW:0]   res;
        logic [IW-1:0] idx;
        int            j;
        res = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(p) + k;
            if (j >= NREQ) j = j - NREQ;
            idx = j[IW-1:0];
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        arb_req = bus.req;
`ifdef TIMER_SHARE_ARB_B2B_EN
        if (state_q == DONE) arb_req[win_q] = 1'b0;
`endif
        {arb_vld, arb_idx} = rr_first(arb_req, ptr_q);
    end

    assign win_req   = bus.req[win_q];
    assign at_term   = (cnt_q == term_q);
    assign grant_now = (state_d == RUN) && (state_q != RUN);

    // State register plus the registered outputs and latched grant context.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            term_q  <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            term_q  <= term_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (arb_vld) state_d = RUN;
            RUN: begin
                if (!win_req)     state_d = IDLE;
                else if (at_term) state_d = DONE;
            end
            DONE: begin
`ifdef TIMER_SHARE_ARB_B2B_EN
                state_d = arb_vld ? RUN : IDLE;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // A dropped request in RUN lands in the IDLE branch, so aborts never pulse done.
    always_comb begin
        gnt_d  = gnt_q;
        done_d = '0;
        cnt_d  = cnt_q;
        term_d = term_q;
        ptr_d  = ptr_q;
        win_d  = win_q;
        if (grant_now) begin
            gnt_d          = '0;
            gnt_d[arb_idx] = 1'b1;
            cnt_d          = '0;
            term_d         = bus.len[arb_idx*CW +: CW];
            win_d          = arb_idx;
            ptr_d          = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        end else if (state_d == IDLE) begin
            gnt_d = '0;
            cnt_d = '0;
        end else if (state_d == DONE) begin
            done_d = gnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.cnt  = cnt_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.last = (state_q == RUN) && at_term;

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rstn) $onehot0(gnt_q));
    a_done_in_gnt: assert property (@(posedge clk) disable iff (!rstn) (done_q & ~gnt_q) == '0);
    a_busy_gnt:    assert property (@(posedge clk) disable iff (!rstn) (state_q != IDLE) == (gnt_q != '0));
endmodule

// File: tb/tb_timer_share_arb.sv
// Scoreboard bench for timer_share_arb: expected grants/completions are queued at stimulus
// time and consumed by a negedge monitor as the DUT produces them.
module tb_timer_share_arb;
    localparam int NREQ = 4;
    localparam int CW   = 4;
`ifdef TIMER_SHARE_ARB_B2B_EN
    localparam int              T2_SPAN = 9;
    localparam logic [NREQ-1:0] T6_GAP  = 4'b0010;
`else
    localparam int              T2_SPAN = 13;
    localparam logic [NREQ-1:0] T6_GAP  = 4'b0000;
`endif

    typedef struct {
        logic [NREQ-1:0] oh;
        int              len;
    } done_t;

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    int              n_chk = 0;
    int              n_err = 0;
    int              cyc   = 0;
    int              gstart = 0;
    logic [NREQ-1:0] prev_gnt = '0;
    logic [NREQ-1:0] gq[$];
    done_t           dq[$];

    timer_share_arb_if #(.NREQ(NREQ), .CW(CW)) bus ();

    timer_share_arb #(.NREQ(NREQ), .CW(CW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_len(input int who, input int v);
        bus.len[who*CW +: CW] = CW'(v);
    endtask

    task automatic expect_txn(input int who, input int l, input bit completes);
        logic [NREQ-1:0] oh;
        done_t           e;
        oh      = '0;
        oh[who] = 1'b1;
        gq.push_back(oh);
        if (completes) begin
            e.oh  = oh;
            e.len = l;
            dq.push_back(e);
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (bus.done == '0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (bus.done == '0) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_cnt(input string tag, input logic [CW-1:0] v);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(bus.gnt != '0 && bus.cnt == v) && k < 60);
        if (!(bus.gnt != '0 && bus.cnt == v)) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        bus.req = '0;
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Monitor: invariants every cycle, grant order and done latency against the queues.
    always @(negedge clk) begin
        done_t e;
        if (!rstn) begin
            prev_gnt = '0;
        end else begin
            chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
            chk("done_in_gnt", 32'(bus.done & ~bus.gnt), 32'd0);
            chk("busy_vs_gnt", 32'(bus.busy), 32'(bus.gnt != '0));
            if (bus.gnt != '0 && bus.gnt != prev_gnt) begin
                gstart = cyc;
                if (gq.size() == 0) chk("grant_unexpected", 32'(bus.gnt), 32'd0);
                else                chk("grant_order", 32'(bus.gnt), 32'(gq.pop_front()));
            end
            if (bus.done != '0) begin
                if (dq.size() == 0) begin
                    chk("done_unexpected", 32'(bus.done), 32'd0);
                end else begin
                    e = dq.pop_front();
                    chk("done_who", 32'(bus.done), 32'(e.oh));
                    chk("done_latency", 32'(cyc - gstart), 32'(e.len + 1));
                end
            end
            prev_gnt = bus.gnt;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int nd;
        int k;
        bus.req = '0;
        bus.len = '0;
        rstn    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_gnt",  32'(bus.gnt),  32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_cnt",  32'(bus.cnt),  32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_last", 32'(bus.last), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_gnt", 32'(bus.gnt), 32'd0);

        // Single requester, len=3: count 0..3, last at 3, done next cycle.
        set_len(0, 3);
        expect_txn(0, 3, 1'b1);
        bus.req = 4'b0001;
        @(negedge clk);
        chk("t1_gnt",  32'(bus.gnt), 32'h1);
        chk("t1_cnt0", 32'(bus.cnt), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("t1_cnt",  32'(bus.cnt), 32'(i));
            chk("t1_last", 32'(bus.last), 32'(i == 3));
        end
        @(negedge clk);
        chk("t1_done",      32'(bus.done), 32'h1);
        chk("t1_cnt_held",  32'(bus.cnt),  32'd3);
        chk("t1_last_done", 32'(bus.last), 32'd0);
        bus.req = '0;
        @(negedge clk);
        chk("t1_busy_fall", 32'(bus.busy), 32'd0);
        chk("t1_gnt_fall",  32'(bus.gnt),  32'd0);
        chk("t1_cnt_clr",   32'(bus.cnt),  32'd0);

        // All four requesting with len=0: strict rotation starting at requester 0.
        do_reset();
        bus.len = '0;
        expect_txn(0, 0, 1'b1);
        expect_txn(1, 0, 1'b1);
        expect_txn(2, 0, 1'b1);
        expect_txn(3, 0, 1'b1);
        expect_txn(0, 0, 1'b1);
        bus.req = 4'b1111;
        first = -1;
        nd    = 0;
        k     = 0;
        while (nd < 5 && k < 100) begin
            @(negedge clk);
            k++;
            if (bus.gnt != '0 && first < 0) first = cyc;
            if (bus.gnt != '0 && bus.done == '0) chk("t2_last", 32'(bus.last), 32'd1);
            if (bus.done != '0) begin
                nd++;
                if (nd == 5) bus.req = '0;
            end
        end
        chk("t2_dones", 32'(nd), 32'd5);
        chk("t2_span", 32'(cyc - first), 32'(T2_SPAN));
        @(negedge clk);

        // Abort: requester 2 drops at cnt=4; no done, then pointer 3 wraps to requester 0.
        set_len(2, 9);
        expect_txn(2, 9, 1'b0);
        bus.req = 4'b0100;
        wait_cnt("t3_cnt4", 4'd4);
        bus.req = '0;
        @(negedge clk);
        chk("t3_abort_gnt",  32'(bus.gnt),  32'd0);
        chk("t3_abort_cnt",  32'(bus.cnt),  32'd0);
        chk("t3_abort_done", 32'(bus.done), 32'd0);
        chk("t3_abort_busy", 32'(bus.busy), 32'd0);
        set_len(0, 2);
        expect_txn(0, 2, 1'b1);
        bus.req = 4'b0101;
        @(negedge clk);
        chk("t3_wrap_gnt", 32'(bus.gnt), 32'h1);
        wait_done("t3_done");
        bus.req = '0;
        @(negedge clk);

        // Full-range interval; len change mid-run must be ignored.
        set_len(1, 15);
        expect_txn(1, 15, 1'b1);
        bus.req = 4'b0010;
        wait_cnt("t4_cnt5", 4'd5);
        set_len(1, 2);
        wait_done("t4_done");
        chk("t4_done_who", 32'(bus.done), 32'h2);
        chk("t4_cnt_top",  32'(bus.cnt),  32'd15);
        bus.req = '0;
        @(negedge clk);

        // Asynchronous reset mid-run clears outputs at once and rewinds the pointer.
        set_len(0, 9);
        expect_txn(0, 9, 1'b0);
        bus.req = 4'b0001;
        wait_cnt("t5_cnt5", 4'd5);
        #1 rstn = 1'b0;
        #1;
        chk("t5_rst_gnt",  32'(bus.gnt),  32'd0);
        chk("t5_rst_done", 32'(bus.done), 32'd0);
        chk("t5_rst_cnt",  32'(bus.cnt),  32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        bus.req = '0;
        @(negedge clk);
        rstn = 1'b1;
        set_len(1, 1);
        set_len(3, 1);
        expect_txn(1, 1, 1'b1);
        bus.req = 4'b1010;
        @(negedge clk);
        chk("t5_first_gnt", 32'(bus.gnt), 32'h2);
        wait_done("t5_done");
        bus.req = '0;
        @(negedge clk);

        // Two requesters with len=1: handover with (B2B) or without an IDLE gap.
        set_len(0, 1);
        set_len(1, 1);
        expect_txn(0, 1, 1'b1);
        expect_txn(1, 1, 1'b1);
        bus.req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_gnt0_hold", 32'(bus.gnt), 32'h1);
        end
        chk("t6_done0", 32'(bus.done), 32'h1);
        @(negedge clk);
        chk("t6_handover", 32'(bus.gnt), 32'(T6_GAP));
        wait_done("t6_done1");
        chk("t6_done1_who", 32'(bus.done), 32'h2);
        bus.req = '0;
        repeat (2) @(negedge clk);

        chk("gq_empty", 32'(gq.size()), 32'd0);
        chk("dq_empty", 32'(dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
